// File: rtl/mesa_ro_arb.sv
// Round-robin Ro-path arbiter: per-channel packet FIFOs merged onto one Mesa Ro byte stream,
// whole packets at a time, with an enforced inter-strobe hold.
module mesa_ro_arb #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned BUSY_HOLD    = 4,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic                  clk_lb,
    input  logic                  reset_l,
    input  logic [NUM_CH-1:0]     ch_byte_en,
    input  logic [8*NUM_CH-1:0]   ch_byte_d,
    input  logic [NUM_CH-1:0]     ch_done,
    output logic [NUM_CH-1:0]     ch_busy,
    output logic                  ro_byte_en,
    output logic [7:0]            ro_byte_d,
    output logic                  ro_done,
    input  logic                  ro_busy,
    input  logic                  clr_err,
    output logic [NUM_CH-1:0]     ovf_err,
    output logic [NUM_CH-1:0]     grant
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned HW = $clog2(BUSY_HOLD + 1);
    localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StDonePend} state_e;

    // FIFO entry: {has_byte, last, byte}
    logic [9:0]        mem_q [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]     wptr_q [NUM_CH];
    logic [PW-1:0]     rptr_q [NUM_CH];
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic [NUM_CH-1:0] wr_ok, ovf_set, nonempty, pop_ch;
    logic [NUM_CH-1:0] busy_q, busy_d, ovf_q, ovf_d;

    state_e            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [GW-1:0]     last_q, last_d, cur_q, cur_d, pick, sel;
    logic              found, sel_ne, pop, issue, can_go, grant_on;
    logic [9:0]        head;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              byte_en_q, byte_en_d, done_q, done_d;
    logic [7:0]        byte_q, byte_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            wr_ok[i]    = (ch_byte_en[i] || ch_done[i]) && (cnt_q[i] != CW'(FIFO_DEPTH));
            ovf_set[i]  = (ch_byte_en[i] || ch_done[i]) && (cnt_q[i] == CW'(FIFO_DEPTH));
            pop_ch[i]   = pop && (sel == GW'(i));
            cnt_d[i]    = cnt_q[i] + CW'(wr_ok[i]) - CW'(pop_ch[i]);
            busy_d[i]   = (CW'(FIFO_DEPTH) - cnt_d[i]) <= CW'(AFULL_MARGIN);
        end
        ovf_d = clr_err ? '0 : (ovf_q | ovf_set);
    end

    always_ff @(posedge clk_lb or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            busy_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ok[i])  wptr_q[i] <= wptr_q[i] + 1'b1;
                if (pop_ch[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
                cnt_q[i] <= cnt_d[i];
            end
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk_lb) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ok[i]) begin
                mem_q[i][wptr_q[i]] <= {ch_byte_en[i], ch_done[i],
                                        ch_byte_en[i] ? ch_byte_d[8*i +: 8] : 8'h00};
            end
        end
    end

    // Round-robin scan starting just after the last served channel.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && nonempty[i] && (i == (int'(last_q) + k) % int'(NUM_CH))) begin
                    found = 1'b1;
                    pick  = GW'(i);
                end
            end
        end
    end

    assign sel    = (state_q == StIdle) ? pick : cur_q;
    assign can_go = (hold_q == '0) && !ro_busy;

    always_comb begin
        head   = '0;
        sel_ne = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == GW'(i)) begin
                head   = mem_q[i][rptr_q[i]];
                sel_ne = nonempty[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        hold_d    = (hold_q != '0) ? hold_q - HW'(1) : '0;
        byte_en_d = 1'b0;
        byte_d    = byte_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        issue     = 1'b0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    cur_d   = pick;
                    state_d = StSend;
                    issue   = 1'b1;
                end
            end
            StSend: issue = 1'b1;
            StDonePend: begin
                if (can_go) begin
                    done_d  = 1'b1;
                    hold_d  = HW'(BUSY_HOLD);
                    last_d  = cur_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // The first pop of a packet may issue in the same cycle as the grant decision.
        if (issue && can_go && sel_ne) begin
            pop    = 1'b1;
            hold_d = HW'(BUSY_HOLD);
            if (head[9]) begin
                byte_en_d = 1'b1;
                byte_d    = head[7:0];
                if (head[8]) state_d = StDonePend;
            end else begin
                done_d  = 1'b1;
                last_d  = sel;
                state_d = StIdle;
            end
        end
        grant_on = (state_d != StIdle) || done_d;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_d[i] = grant_on && (cur_d == GW'(i));
        end
    end

    always_ff @(posedge clk_lb or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            last_q    <= GW'(NUM_CH - 1);
            hold_q    <= '0;
            grant_q   <= '0;
            byte_en_q <= 1'b0;
            byte_q    <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            byte_en_q <= byte_en_d;
            byte_q    <= byte_d;
            done_q    <= done_d;
        end
    end

    assign ch_busy    = busy_q;
    assign ovf_err    = ovf_q;
    assign grant      = grant_q;
    assign ro_byte_en = byte_en_q;
    assign ro_byte_d  = byte_q;
    assign ro_done    = done_q;

endmodule

// File: tb/tb_mesa_ro_arb.sv
// Directed bench for mesa_ro_arb: packet table plus hand-written multi-cycle sequences.
module tb_mesa_ro_arb;

    logic        clk_lb = 1'b0;
    logic        reset_l = 1'b0;
    logic [1:0]  ch_byte_en = '0;
    logic [15:0] ch_byte_d = '0;
    logic [1:0]  ch_done = '0;
    logic [1:0]  ch_busy;
    logic        ro_byte_en;
    logic [7:0]  ro_byte_d;
    logic        ro_done;
    logic        ro_busy = 1'b0;
    logic        clr_err = 1'b0;
    logic [1:0]  ovf_err;
    logic [1:0]  grant;

    mesa_ro_arb #(
        .NUM_CH(2), .FIFO_DEPTH(16), .BUSY_HOLD(4), .AFULL_MARGIN(4)
    ) dut (
        .clk_lb(clk_lb), .reset_l(reset_l), .ch_byte_en(ch_byte_en), .ch_byte_d(ch_byte_d),
        .ch_done(ch_done), .ch_busy(ch_busy), .ro_byte_en(ro_byte_en), .ro_byte_d(ro_byte_d),
        .ro_done(ro_done), .ro_busy(ro_busy), .clr_err(clr_err), .ovf_err(ovf_err),
        .grant(grant)
    );

    always #5 clk_lb = ~clk_lb;

    typedef struct {
        int          cyc;
        bit          is_done;
        logic [7:0]  d;
        logic [1:0]  g;
    } ev_t;

    typedef struct {
        int          ch;
        int          len;
        logic [31:0] d;
        bit          combo;
        logic [1:0]  exp_g;
        int          exp_gap;
    } vec_t;

    ev_t  log_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   last_s = -100;
    logic prev_busy = 1'b0;
    vec_t vecs[5];

    always @(posedge clk_lb) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Strobe monitor: gating by ro_busy and minimum spacing hold on every strobe.
    initial forever begin
        @(negedge clk_lb);
        if (!reset_l) begin
            last_s = -100;
        end else begin
            if (ro_byte_en || ro_done) begin
                chk("busy_gate", int'(prev_busy), 0);
                chk("spacing_ok", int'((cyc - last_s) >= 5), 1);
                last_s = cyc;
            end
            if (ro_byte_en) log_q.push_back('{cyc, 1'b0, ro_byte_d, grant});
            if (ro_done)    log_q.push_back('{cyc, 1'b1, 8'h00, grant});
        end
        prev_busy = ro_busy;
    end

    task automatic tick();
        @(posedge clk_lb);
        #1;
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        repeat (2) tick();
        reset_l = 1'b1;
        tick();
    endtask

    task automatic send_pkt(input int ch, input int len, input logic [31:0] d, input bit combo,
                            output int wcyc);
        wcyc = cyc;
        for (int j = 0; j < len; j++) begin
            ch_byte_en[ch]        = 1'b1;
            ch_byte_d[8*ch +: 8]  = d[8*j +: 8];
            ch_done[ch]           = combo && (j == len - 1);
            tick();
            ch_byte_en = '0;
            ch_done    = '0;
        end
        if (!combo) begin
            ch_done[ch] = 1'b1;
            tick();
            ch_done = '0;
        end
    endtask

    task automatic wait_ev(input string nm, input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({nm, "_timeout"}, int'(log_q.size() >= n), 1);
    endtask

    function automatic int ev_cyc(input int idx);
        if (idx < 0 || idx >= log_q.size()) return -1000;
        return log_q[idx].cyc;
    endfunction

    task automatic ev_chk(input string nm, input int idx, input bit isd, input logic [7:0] d,
                          input logic [1:0] g);
        if (idx >= log_q.size()) begin
            chk({nm, "_missing"}, log_q.size(), idx + 1);
        end else begin
            chk({nm, "_kind"}, int'(log_q[idx].is_done), int'(isd));
            if (!isd) chk({nm, "_data"}, int'(log_q[idx].d), int'(d));
            chk({nm, "_grant"}, int'(log_q[idx].g), int'(g));
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_byte_en"}, int'(ro_byte_en), 0);
        chk({nm, "_byte_d"}, int'(ro_byte_d), 0);
        chk({nm, "_done"}, int'(ro_done), 0);
        chk({nm, "_grant"}, int'(grant), 0);
        chk({nm, "_ch_busy"}, int'(ch_busy), 0);
        chk({nm, "_ovf"}, int'(ovf_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n;

        vecs[0] = '{ch: 0, len: 3, d: 32'h0034_12F0, combo: 1'b0, exp_g: 2'b01, exp_gap: 5};
        vecs[1] = '{ch: 1, len: 2, d: 32'h0000_5AA5, combo: 1'b0, exp_g: 2'b10, exp_gap: 5};
        vecs[2] = '{ch: 0, len: 1, d: 32'h0000_0055, combo: 1'b1, exp_g: 2'b01, exp_gap: 5};
        vecs[3] = '{ch: 1, len: 4, d: 32'h0180_FF00, combo: 1'b1, exp_g: 2'b10, exp_gap: 5};
        vecs[4] = '{ch: 1, len: 0, d: 32'h0000_0000, combo: 1'b0, exp_g: 2'b10, exp_gap: 5};

        // Reset state
        repeat (3) tick();
        chk_outputs_zero("reset");
        reset_l = 1'b1;
        repeat (2) tick();
        chk_outputs_zero("post_reset");

        // Single-packet table
        for (int r = 0; r < 5; r++) begin
            log_q.delete();
            send_pkt(vecs[r].ch, vecs[r].len, vecs[r].d, vecs[r].combo, w);
            n = vecs[r].len + 1;
            wait_ev($sformatf("vec%0d", r), n, 100);
            for (int j = 0; j < vecs[r].len; j++)
                ev_chk($sformatf("vec%0d_b%0d", r, j), j, 1'b0, vecs[r].d[8*j +: 8], vecs[r].exp_g);
            ev_chk($sformatf("vec%0d_done", r), n - 1, 1'b1, 8'h00, vecs[r].exp_g);
            chk($sformatf("vec%0d_latency", r), ev_cyc(0) - w, 2);
            for (int j = 1; j < n; j++)
                chk($sformatf("vec%0d_gap%0d", r, j), ev_cyc(j) - ev_cyc(j - 1), vecs[r].exp_gap);
            repeat (12) tick();
            chk($sformatf("vec%0d_count", r), log_q.size(), n);
            chk($sformatf("vec%0d_idle_grant", r), int'(grant), 0);
        end

        // Two channels loaded together: ch0 first after reset, no interleaving
        do_reset();
        log_q.delete();
        ch_byte_en = 2'b11; ch_byte_d = 16'hB0A0; tick();
        ch_byte_d = 16'hB1A1; tick();
        ch_byte_en = 2'b00; ch_done = 2'b11; tick();
        ch_done = 2'b00;
        wait_ev("pair", 6, 150);
        ev_chk("pair_a0", 0, 1'b0, 8'hA0, 2'b01);
        ev_chk("pair_a1", 1, 1'b0, 8'hA1, 2'b01);
        ev_chk("pair_ad", 2, 1'b1, 8'h00, 2'b01);
        ev_chk("pair_b0", 3, 1'b0, 8'hB0, 2'b10);
        ev_chk("pair_b1", 4, 1'b0, 8'hB1, 2'b10);
        ev_chk("pair_bd", 5, 1'b1, 8'h00, 2'b10);
        for (int j = 1; j < 6; j++)
            chk($sformatf("pair_gap%0d", j), ev_cyc(j) - ev_cyc(j - 1), 5);
        repeat (12) tick();
        chk("pair_count", log_q.size(), 6);

        // Round-robin: after ch0 is served, a simultaneous pair goes ch1 first
        log_q.delete();
        send_pkt(0, 1, 32'h0000_00C0, 1'b1, w);
        wait_ev("rr_pre", 2, 50);
        repeat (10) tick();
        log_q.delete();
        ch_byte_en = 2'b11; ch_done = 2'b11; ch_byte_d = 16'hE0D0; tick();
        ch_byte_en = 2'b00; ch_done = 2'b00;
        wait_ev("rr", 4, 100);
        ev_chk("rr_e0", 0, 1'b0, 8'hE0, 2'b10);
        ev_chk("rr_ed", 1, 1'b1, 8'h00, 2'b10);
        ev_chk("rr_d0", 2, 1'b0, 8'hD0, 2'b01);
        ev_chk("rr_dd", 3, 1'b1, 8'h00, 2'b01);
        repeat (12) tick();

        // Overflow with PHY busy: 20 writes into a 16-deep FIFO
        log_q.delete();
        ro_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ch_byte_en[0] = 1'b1; ch_byte_d[7:0] = 8'(i); tick();
            if (i == 10) chk("afull_cnt11", int'(ch_busy[0]), 0);
            if (i == 11) chk("afull_cnt12", int'(ch_busy[0]), 1);
            if (i == 15) chk("ovf_at_full", int'(ovf_err[0]), 0);
            if (i == 16) chk("ovf_on_drop", int'(ovf_err[0]), 1);
        end
        ch_byte_en = '0;
        repeat (3) tick();
        chk("ovf_sticky", int'(ovf_err), 1);
        chk("ovf_no_strobe", log_q.size(), 0);
        ch_byte_en[0] = 1'b1; clr_err = 1'b1; tick();
        ch_byte_en = '0; clr_err = 1'b0;
        chk("clr_wins", int'(ovf_err[0]), 0);
        ch_byte_en[0] = 1'b1; tick();
        ch_byte_en = '0;
        chk("ovf_reset", int'(ovf_err[0]), 1);
        clr_err = 1'b1; tick();
        clr_err = 1'b0;
        chk("ovf_cleared", int'(ovf_err[0]), 0);
        ro_busy = 1'b0;
        wait_ev("ovf_first", 1, 20);
        send_pkt(0, 0, 32'h0, 1'b0, w);
        wait_ev("ovf_drain", 17, 200);
        for (int j = 0; j < 16; j++)
            ev_chk($sformatf("ovf_b%0d", j), j, 1'b0, 8'(j), 2'b01);
        ev_chk("ovf_done", 16, 1'b1, 8'h00, 2'b01);
        repeat (12) tick();
        chk("ovf_count", log_q.size(), 17);
        chk("ovf_busy_clear", int'(ch_busy), 0);
        chk("ovf_err_after", int'(ovf_err), 0);

        // ro_busy held for 7 clocks mid-packet
        log_q.delete();
        send_pkt(1, 4, 32'h4433_2211, 1'b0, w);
        ro_busy = 1'b1;
        repeat (7) tick();
        ro_busy = 1'b0;
        wait_ev("stall", 5, 100);
        ev_chk("stall_b0", 0, 1'b0, 8'h11, 2'b10);
        ev_chk("stall_b1", 1, 1'b0, 8'h22, 2'b10);
        ev_chk("stall_b2", 2, 1'b0, 8'h33, 2'b10);
        ev_chk("stall_b3", 3, 1'b0, 8'h44, 2'b10);
        ev_chk("stall_done", 4, 1'b1, 8'h00, 2'b10);
        chk("stall_gap", int'((ev_cyc(1) - ev_cyc(0)) > 5), 1);
        repeat (12) tick();
        chk("stall_count", log_q.size(), 5);

        // Asynchronous reset mid-packet
        log_q.delete();
        send_pkt(0, 3, 32'h0099_8877, 1'b1, w);
        chk("rst_mid_started", int'(log_q.size() >= 1), 1);
        chk("rst_mid_granted", int'(grant), 1);
        #2;
        reset_l = 1'b0;
        #1;
        chk_outputs_zero("rst_async");
        repeat (3) tick();
        reset_l = 1'b1;
        log_q.delete();
        repeat (30) tick();
        chk("rst_no_residue", log_q.size(), 0);
        chk("rst_idle_grant", int'(grant), 0);
        send_pkt(0, 1, 32'h0000_005A, 1'b1, w);
        wait_ev("rst_next", 2, 50);
        ev_chk("rst_next_b", 0, 1'b0, 8'h5A, 2'b01);
        ev_chk("rst_next_d", 1, 1'b1, 8'h00, 2'b01);
        chk("rst_next_latency", ev_cyc(0) - w, 2);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
